// File: rtl/interlaken_milestone_timer_if.sv
// Readout port between the milestone timer and the latency-measurement logging path.
// The logger drives rd_en/rd_idx; the timer answers one cycle later with rd_valid/rd_data.
interface interlaken_milestone_timer_if #(
  parameter int CNT_W = 32
);
  logic             rd_en;
  logic [3:0]       rd_idx;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;

  modport master (output rd_en, rd_idx, input rd_valid, rd_data);
  modport slave  (input rd_en, rd_idx, output rd_valid, rd_data);
endinterface

// File: rtl/interlaken_milestone_timer.sv
// Timestamps first rising edges of the loopback sequencer milestone flags and measures START->STOP latency.
// Optional ILKN_LAT_MINMAX_EN adds lat_min/lat_max/run_cnt statistics that survive clear.
module interlaken_milestone_timer #(
  parameter int NUM_EVT   = 9,
  parameter int CNT_W     = 32,
  parameter int START_IDX = 2,
  parameter int STOP_IDX  = 4
) (
  input  logic                       init_clk,
  input  logic                       clk_reset_n,
  input  logic [NUM_EVT-1:0]         evt_in,
  input  logic                       clear,
  interlaken_milestone_timer_if.slave rd_if,
  output logic [NUM_EVT-1:0]         evt_seen,
  output logic                       lat_valid,
  output logic [CNT_W-1:0]           lat_cycles,
  output logic                       lat_err,
  output logic                       order_err,
  output logic                       cnt_ovf
`ifdef ILKN_LAT_MINMAX_EN
  ,
  output logic [CNT_W-1:0]           lat_min,
  output logic [CNT_W-1:0]           lat_max,
  output logic [7:0]                 run_cnt
`endif
);

  // state      | meaning
  // IDLE       | waiting for milestone 0, counter parked at 0
  // RUN        | counter free-running (saturating), capturing first edges
  // WAIT_START | latency window not yet opened
  // WAIT_STOP  | START stamped, waiting for STOP
  // LAT_DONE   | lat_cycles valid until clear
  typedef enum logic {IDLE, RUN} run_state_e;
  typedef enum logic [1:0] {WAIT_START, WAIT_STOP, LAT_DONE} lat_state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  run_state_e         run_q;
  lat_state_e         lat_q;
  logic [NUM_EVT-1:0] evt_q;
  logic [NUM_EVT-1:0] seen_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   ts_q [NUM_EVT];
  logic               lat_valid_q;
  logic [CNT_W-1:0]   lat_cycles_q;
  logic               lat_err_q;
  logic               order_err_q;
  logic               cnt_ovf_q;
  logic               rd_valid_q;
  logic [CNT_W-1:0]   rd_data_q;

  logic [NUM_EVT-1:0] rise;
  logic [NUM_EVT-1:0] cap_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [CNT_W-1:0]   rd_sel_d;

  assign rise = evt_in & ~evt_q;

  always_comb begin
    cap_d = '0;
    cnt_d = cnt_q;
    if (run_q == IDLE) begin
      cap_d[0] = rise[0];
      if (rise[0]) cnt_d = CNT_ONE;
    end else begin
      cap_d = rise & ~seen_q;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Unseen or out-of-range indices read as 0; values are pre-capture for this cycle.
  always_comb begin
    rd_sel_d = '0;
    for (int i = 0; i < NUM_EVT; i++) begin
      if (rd_if.rd_idx == 4'(i) && seen_q[i]) rd_sel_d = ts_q[i];
    end
  end

  always_ff @(posedge init_clk or negedge clk_reset_n) begin
    if (!clk_reset_n) begin
      run_q        <= IDLE;
      lat_q        <= WAIT_START;
      evt_q        <= '0;
      seen_q       <= '0;
      cnt_q        <= '0;
      for (int i = 0; i < NUM_EVT; i++) ts_q[i] <= '0;
      lat_valid_q  <= 1'b0;
      lat_cycles_q <= '0;
      lat_err_q    <= 1'b0;
      order_err_q  <= 1'b0;
      cnt_ovf_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      evt_q      <= evt_in;
      rd_valid_q <= rd_if.rd_en;
      if (rd_if.rd_en) rd_data_q <= clear ? '0 : rd_sel_d;

      if (clear) begin
        run_q        <= IDLE;
        lat_q        <= WAIT_START;
        seen_q       <= '0;
        cnt_q        <= '0;
        for (int i = 0; i < NUM_EVT; i++) ts_q[i] <= '0;
        lat_valid_q  <= 1'b0;
        lat_cycles_q <= '0;
        lat_err_q    <= 1'b0;
        order_err_q  <= 1'b0;
        cnt_ovf_q    <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        seen_q <= seen_q | cap_d;
        for (int i = 0; i < NUM_EVT; i++) begin
          if (cap_d[i]) ts_q[i] <= cnt_q;
        end

        if (run_q == IDLE) begin
          if (|rise[NUM_EVT-1:1]) order_err_q <= 1'b1;
          if (rise[0]) run_q <= RUN;
        end else if (cnt_q == CNT_MAX) begin
          cnt_ovf_q <= 1'b1;
        end

        case (lat_q)
          WAIT_START: begin
            if (cap_d[START_IDX]) begin
              if (cap_d[STOP_IDX]) begin
                lat_cycles_q <= '0;
                lat_valid_q  <= 1'b1;
                lat_q        <= LAT_DONE;
              end else begin
                lat_q <= WAIT_STOP;
              end
            end else if (cap_d[STOP_IDX]) begin
              lat_err_q <= 1'b1;
            end
          end
          WAIT_STOP: begin
            if (cap_d[STOP_IDX]) begin
              lat_cycles_q <= cnt_q - ts_q[START_IDX];
              lat_valid_q  <= 1'b1;
              lat_q        <= LAT_DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign evt_seen       = seen_q;
  assign lat_valid      = lat_valid_q;
  assign lat_cycles     = lat_cycles_q;
  assign lat_err        = lat_err_q;
  assign order_err      = order_err_q;
  assign cnt_ovf        = cnt_ovf_q;
  assign rd_if.rd_valid = rd_valid_q;
  assign rd_if.rd_data  = rd_data_q;

`ifdef ILKN_LAT_MINMAX_EN
  logic             lat_valid_prev_q;
  logic [CNT_W-1:0] lat_min_q;
  logic [CNT_W-1:0] lat_max_q;
  logic [7:0]       run_cnt_q;

  // Statistics deliberately ignore clear so they accumulate across runs.
  always_ff @(posedge init_clk or negedge clk_reset_n) begin
    if (!clk_reset_n) begin
      lat_valid_prev_q <= 1'b0;
      lat_min_q        <= '1;
      lat_max_q        <= '0;
      run_cnt_q        <= '0;
    end else begin
      lat_valid_prev_q <= lat_valid_q;
      if (lat_valid_q && !lat_valid_prev_q) begin
        if (run_cnt_q == 8'd0 || lat_cycles_q < lat_min_q) lat_min_q <= lat_cycles_q;
        if (run_cnt_q == 8'd0 || lat_cycles_q > lat_max_q) lat_max_q <= lat_cycles_q;
        if (run_cnt_q != 8'hFF) run_cnt_q <= run_cnt_q + 8'd1;
      end
    end
  end

  assign lat_min = lat_min_q;
  assign lat_max = lat_max_q;
  assign run_cnt = run_cnt_q;
`endif

endmodule

// File: tb/tb_interlaken_milestone_timer.sv
// Bench for interlaken_milestone_timer: a 32-bit and an 8-bit instance share stimulus and are
// checked every cycle against a cycle-count model, plus hand-computed directed expectations.
module tb_interlaken_milestone_timer;
  localparam int NE    = 9;
  localparam int START = 2;
  localparam int STOP  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NE-1:0] evt;
  logic          clr;
  logic          rd_en;
  logic [3:0]    rd_idx;

  interlaken_milestone_timer_if #(.CNT_W(32)) rif_a ();
  interlaken_milestone_timer_if #(.CNT_W(8))  rif_b ();
  assign rif_a.rd_en  = rd_en;
  assign rif_a.rd_idx = rd_idx;
  assign rif_b.rd_en  = rd_en;
  assign rif_b.rd_idx = rd_idx;

  logic [NE-1:0] seen_a, seen_b;
  logic          lv_a, lv_b, le_a, le_b, oe_a, oe_b, ov_a, ov_b;
  logic [31:0]   lc_a;
  logic [7:0]    lc_b;
`ifdef ILKN_LAT_MINMAX_EN
  logic [31:0]   min_a, max_a;
  logic [7:0]    min_b, max_b, run_a, run_b;
`endif

  interlaken_milestone_timer #(.NUM_EVT(NE), .CNT_W(32), .START_IDX(START), .STOP_IDX(STOP)) dut_a (
    .init_clk(clk), .clk_reset_n(rst_n), .evt_in(evt), .clear(clr), .rd_if(rif_a),
    .evt_seen(seen_a), .lat_valid(lv_a), .lat_cycles(lc_a), .lat_err(le_a),
    .order_err(oe_a), .cnt_ovf(ov_a)
`ifdef ILKN_LAT_MINMAX_EN
    , .lat_min(min_a), .lat_max(max_a), .run_cnt(run_a)
`endif
  );

  interlaken_milestone_timer #(.NUM_EVT(NE), .CNT_W(8), .START_IDX(START), .STOP_IDX(STOP)) dut_b (
    .init_clk(clk), .clk_reset_n(rst_n), .evt_in(evt), .clear(clr), .rd_if(rif_b),
    .evt_seen(seen_b), .lat_valid(lv_b), .lat_cycles(lc_b), .lat_err(le_b),
    .order_err(oe_b), .cnt_ovf(ov_b)
`ifdef ILKN_LAT_MINMAX_EN
    , .lat_min(min_b), .lat_max(max_b), .run_cnt(run_b)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a run starts at edge e0; the timestamp of a later edge e is min(e - e0, max).
  longint unsigned mmax [2];
  bit              m_run [2];
  longint unsigned m_e0 [2];
  bit [NE-1:0]     m_seen [2];
  longint unsigned m_ts [2][NE];
  bit              m_lv [2], m_le [2], m_oe [2], m_ov [2], m_rv [2], m_lvp [2];
  longint unsigned m_lat [2], m_rd [2], m_min [2], m_max [2];
  int              m_runs [2];
  longint unsigned edge_n;
  bit [NE-1:0]     evt_prev;
  bit              model_on = 1'b0;

  task automatic model_reset();
    mmax[0] = 64'hFFFF_FFFF;
    mmax[1] = 64'hFF;
    edge_n = 0;
    evt_prev = '0;
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_e0[k] = 0; m_seen[k] = '0;
      for (int i = 0; i < NE; i++) m_ts[k][i] = 0;
      m_lv[k] = 0; m_le[k] = 0; m_oe[k] = 0; m_ov[k] = 0; m_rv[k] = 0; m_lvp[k] = 0;
      m_lat[k] = 0; m_rd[k] = 0; m_min[k] = mmax[k]; m_max[k] = 0; m_runs[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit [NE-1:0] rise);
    bit [NE-1:0]     nc;
    longint unsigned cv;
    if (rd_en) begin
      m_rv[k] = 1;
      if (clr || rd_idx >= NE) m_rd[k] = 0;
      else m_rd[k] = m_seen[k][rd_idx] ? m_ts[k][rd_idx] : 0;
    end else begin
      m_rv[k] = 0;
    end
    if (m_lv[k] && !m_lvp[k]) begin
      if (m_runs[k] == 0 || m_lat[k] < m_min[k]) m_min[k] = m_lat[k];
      if (m_runs[k] == 0 || m_lat[k] > m_max[k]) m_max[k] = m_lat[k];
      if (m_runs[k] < 255) m_runs[k]++;
    end
    m_lvp[k] = m_lv[k];
    if (clr) begin
      m_run[k] = 0; m_seen[k] = '0;
      for (int i = 0; i < NE; i++) m_ts[k][i] = 0;
      m_lv[k] = 0; m_le[k] = 0; m_oe[k] = 0; m_ov[k] = 0; m_lat[k] = 0;
    end else if (!m_run[k]) begin
      if (rise[NE-1:1] != 0) m_oe[k] = 1;
      if (rise[0]) begin
        m_run[k] = 1; m_e0[k] = edge_n; m_seen[k][0] = 1; m_ts[k][0] = 0;
      end
    end else begin
      cv = edge_n - m_e0[k];
      if (cv >= mmax[k]) begin
        cv = mmax[k];
        m_ov[k] = 1;
      end
      nc = rise & ~m_seen[k];
      if (nc[STOP]) begin
        if (m_seen[k][START]) begin
          m_lat[k] = (cv - m_ts[k][START]) & mmax[k];
          m_lv[k] = 1;
        end else if (nc[START]) begin
          m_lat[k] = 0;
          m_lv[k] = 1;
        end else begin
          m_le[k] = 1;
        end
      end
      for (int i = 0; i < NE; i++) if (nc[i]) m_ts[k][i] = cv;
      m_seen[k] = m_seen[k] | nc;
    end
  endtask

  always @(posedge clk) begin : model_proc
    bit [NE-1:0] rise;
    if (model_on) begin
      rise = evt & ~evt_prev;
      edge_n++;
      model_step(0, rise);
      model_step(1, rise);
      evt_prev = evt;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("seen_a", seen_a, m_seen[0]);      chk("seen_b", seen_b, m_seen[1]);
      chk("lat_valid_a", lv_a, m_lv[0]);     chk("lat_valid_b", lv_b, m_lv[1]);
      chk("lat_cycles_a", lc_a, m_lat[0]);   chk("lat_cycles_b", lc_b, m_lat[1]);
      chk("lat_err_a", le_a, m_le[0]);       chk("lat_err_b", le_b, m_le[1]);
      chk("order_err_a", oe_a, m_oe[0]);     chk("order_err_b", oe_b, m_oe[1]);
      chk("cnt_ovf_a", ov_a, m_ov[0]);       chk("cnt_ovf_b", ov_b, m_ov[1]);
      chk("rd_valid_a", rif_a.rd_valid, m_rv[0]); chk("rd_valid_b", rif_b.rd_valid, m_rv[1]);
      chk("rd_data_a", rif_a.rd_data, m_rd[0]);   chk("rd_data_b", rif_b.rd_data, m_rd[1]);
`ifdef ILKN_LAT_MINMAX_EN
      chk("lat_min_a", min_a, m_min[0]);     chk("lat_min_b", min_b, m_min[1]);
      chk("lat_max_a", max_a, m_max[0]);     chk("lat_max_b", max_b, m_max[1]);
      chk("run_cnt_a", run_a, m_runs[0]);    chk("run_cnt_b", run_b, m_runs[1]);
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input int idx, input longint unsigned exp_a, input string nm);
    rd_en = 1'b1;
    rd_idx = 4'(idx);
    cyc(1);
    rd_en = 1'b0;
    chk({nm, "_valid"}, rif_a.rd_valid, 1);
    chk(nm, rif_a.rd_data, exp_a);
    cyc(1);
    chk({nm, "_drop"}, rif_a.rd_valid, 0);
  endtask

  task automatic clear_with_rise(input int idx);
    evt[idx] = 1'b1;
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clr_seen", seen_a, 0);
    chk("clr_lat_valid", lv_a, 0);
    chk("clr_lat_cycles", lc_a, 0);
    chk("clr_errs", {le_a, oe_a, ov_a, le_b, oe_b, ov_b}, 0);
    evt = '0;
    cyc(2);
  endtask

  initial begin
    evt = '0; clr = 1'b0; rd_en = 1'b0; rd_idx = '0;
    model_reset();
    cyc(3);
    chk("rst_seen", seen_a, 0);
    chk("rst_lat", {lv_a, le_a, oe_a, ov_a}, 0);
    chk("rst_lat_cycles", lc_a, 0);
    chk("rst_rd", rif_a.rd_valid, 0);
    chk("rst_rd_data", rif_a.rd_data, 0);
`ifdef ILKN_LAT_MINMAX_EN
    chk("rst_lat_min", min_a, 64'hFFFF_FFFF);
    chk("rst_run_cnt", run_a, 0);
`endif
    rst_n = 1'b1;
    model_on = 1'b1;
    cyc(10);

    // Run 1: START 100 cycles after milestone 0, STOP 1000 cycles later.
    evt[0] = 1'b1; cyc(100);
    evt[2] = 1'b1; cyc(1000);
    evt[4] = 1'b1;
    chk("t1_lat_valid_pre", lv_a, 0);
    cyc(1);
    chk("t1_lat_valid", lv_a, 1);
    chk("t1_lat_cycles", lc_a, 1000);
    chk("t1_lat_cycles_b", lc_b, 155);
    chk("t1_ovf_b", ov_b, 1);
    chk("t1_ovf_a", ov_a, 0);
    rd(0, 0, "t1_ts0");
    rd(2, 100, "t1_ts2");
    rd(4, 1100, "t1_ts4");
    rd(12, 0, "t1_idx12");

    // Clear coincident with a rise and a readout: nothing captured, read returns 0.
    rd_en = 1'b1; rd_idx = 4'd2;
    clear_with_rise(1);
    rd_en = 1'b0;
    chk("t1_rd_clear_data", rif_a.rd_data, 0);

    // Run 2: latency 400.
    evt[0] = 1'b1; cyc(10);
    evt[2] = 1'b1; cyc(400);
    evt[4] = 1'b1; cyc(1);
    chk("t2_lat_cycles", lc_a, 400);
    cyc(1);
`ifdef ILKN_LAT_MINMAX_EN
    chk("t2_lat_min", min_a, 400);
    chk("t2_lat_max", max_a, 1000);
    chk("t2_run_cnt", run_a, 2);
`endif
    clr = 1'b1; cyc(1); clr = 1'b0;
    evt = '0; cyc(2);

    // Milestone raised while IDLE is lost and flagged.
    evt[3] = 1'b1; cyc(2);
    evt[0] = 1'b1; cyc(1);
    chk("t3_order_err", oe_a, 1);
    chk("t3_seen", seen_a, 9'b0_0000_0001);
    rd(3, 0, "t3_ts3");
    clr = 1'b1; cyc(1); clr = 1'b0;
    evt = '0; cyc(2);

    // STOP before START.
    evt[0] = 1'b1; cyc(5);
    evt[4] = 1'b1; cyc(1);
    chk("t4_lat_err", le_a, 1);
    cyc(5);
    evt[2] = 1'b1; cyc(3);
    chk("t4_lat_valid", lv_a, 0);
    chk("t4_seen", seen_a, 9'b0_0001_0101);
    clr = 1'b1; cyc(1); clr = 1'b0;
    evt = '0; cyc(2);

    // START and STOP together, then same-cycle read/capture and back-to-back reads.
    evt[0] = 1'b1; cyc(7);
    evt[2] = 1'b1; evt[4] = 1'b1; cyc(1);
    chk("t5_lat_valid", lv_a, 1);
    chk("t5_lat_cycles", lc_a, 0);
    rd(2, 7, "t5_ts2");
    rd(4, 7, "t5_ts4");
    rd(12, 0, "t5_idx12");
    evt[5] = 1'b1; rd_en = 1'b1; rd_idx = 4'd5; cyc(1);
    chk("t5_rd_same_cycle", rif_a.rd_data, 0);
    cyc(1);
    chk("t5_rd_b2b_valid", rif_a.rd_valid, 1);
    chk("t5_rd_b2b", rif_a.rd_data, 14);
    rd_en = 1'b0; cyc(1);
    chk("t5_rd_idle", rif_a.rd_valid, 0);
    chk("t5_rd_hold", rif_a.rd_data, 14);
    cyc(300);
    chk("t5_ovf_b", ov_b, 1);
    chk("t5_ovf_a", ov_a, 0);
    clear_with_rise(7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/interlaken_milestone_timer.md
Name: interlaken_milestone_timer

Overview:
- Sits directly downstream of the Interlaken loopback test sequencer and consumes its nine sticky milestone flags (reset released, GT locked, RX aligned, all sent, all received, idle, restart, busy, test passed).
- Timestamps the first rising edge of each flag against a free-running init_clk cycle counter.
- Computes the packet-phase latency between two chosen milestones.
- Provides a register-style readout port to the latency-measurement logging path.

Parameters:
- NUM_EVT, 9: number of milestone inputs; index i corresponds to milestone i+1.
- CNT_W, 32: timestamp and latency width in bits.
- START_IDX, 2: milestone index that opens the latency window (RX aligned, generation start).
- STOP_IDX, 4: milestone index that closes the latency window (all packets received).

Ports:
- init_clk  in  1  sole clock.
- clk_reset_n  in  1  asynchronous, active-low reset.
- evt_in  in  NUM_EVT  milestone levels, synchronous to init_clk; once high they stay high until the sequencer resets.
- clear  in  1  synchronous single-cycle re-arm pulse.
- rd_en  in  1  readout request pulse.
- rd_idx  in  4  timestamp index to read.
- rd_valid  out  1  one-cycle readout strobe.
- rd_data  out  CNT_W  readout timestamp.
- evt_seen  out  NUM_EVT  sticky flag per captured milestone.
- lat_valid  out  1  latency result available (sticky).
- lat_cycles  out  CNT_W  latency in cycles, computed as ts[STOP_IDX] - ts[START_IDX].
- lat_err  out  1  sticky flag: STOP edge arrived before START.
- order_err  out  1  sticky flag: an edge on index>0 arrived while IDLE.
- cnt_ovf  out  1  sticky flag: counter saturated.

Behaviour:
- Reset (clk_reset_n low, asynchronous): every output is 0. Counter, timestamps and evt_q are 0. FSM is IDLE.
- Edge detection: evt_q registers evt_in every cycle. rise = evt_in & ~evt_q. Inputs are already in the init_clk domain, so no synchroniser is used.
- Main FSM states: IDLE, RUN.
  - IDLE: counter holds 0.
    - On rise[0]: capture ts[0]=0, set evt_seen[0], load counter to 1, go to RUN.
    - rise[i] for i>0 while IDLE: event is not captured and order_err is set. Because the flag stays high, that milestone is lost until clear and a fresh 0-to-1 edge.
  - RUN: counter increments by 1 every cycle.
    - At all-ones it holds and sets cnt_ovf.
    - For each i with rise[i] and !evt_seen[i]: ts[i] <= current counter value, and evt_seen[i] is set.
    - Several simultaneous rises all capture the same value.
    - Second and later rises of an index are ignored (first-occurrence capture).
- Latency sub-FSM states: WAIT_START, WAIT_STOP, LAT_DONE.
  - WAIT_START -> WAIT_STOP when START is captured.
  - WAIT_STOP -> LAT_DONE when STOP is captured. The subtraction is registered, so lat_valid rises exactly 1 cycle after the STOP capture edge and lat_cycles is stable from that cycle on.
  - If STOP is captured while in WAIT_START: set lat_err, stay in WAIT_START, and never assert lat_valid for this run.
  - If START and STOP are captured in the same cycle: lat_cycles=0 and lat_valid is asserted.
  - Subtraction is modulo 2^CNT_W. It cannot wrap in practice, because the counter saturates rather than wrapping.
- Readout:
  - rd_en in cycle N gives rd_valid=1 in cycle N+1 for exactly one cycle. rd_data is ts[rd_idx] sampled at N.
  - rd_data is 0 when rd_idx>=NUM_EVT or the index is not yet seen.
  - Read and capture of the same index in the same cycle returns the pre-capture value (0).
  - rd_en is accepted every cycle (back-to-back reads allowed).
  - rd_data holds its last value when rd_valid=0.
- Clear:
  - Takes priority over any rise in the same cycle.
  - Returns both FSMs to IDLE/WAIT_START.
  - Zeroes the counter, timestamps, evt_seen, lat_*, order_err and cnt_ovf.
  - evt_q is not cleared, so levels already high do not re-trigger; a re-run needs the sequencer to drop and re-raise its flags.
  - A pending readout still completes with post-clear data (0).

Optional Feature:
- Macro ILKN_LAT_MINMAX_EN.
- Defined:
  - Extra outputs lat_min[CNT_W], lat_max[CNT_W] and run_cnt[8].
  - Updated one cycle after each lat_valid rising edge; the first run loads both min and max.
  - run_cnt saturates at 255.
  - These three values survive clear and are reset only by clk_reset_n. Reset values: lat_min all-ones, lat_max 0, run_cnt 0.
- Undefined: these ports and registers do not exist. Behaviour is otherwise identical.

Test Plan:
- Release reset; raise evt_in[0] at cycle 10, evt_in[2] at 110, evt_in[4] at 1110 -> ts[0]=0, ts[2]=100, ts[4]=1100; lat_valid rises at 1111 with lat_cycles=1000.
- Raise evt_in[3] while IDLE, then evt_in[0] -> order_err=1, evt_seen[3]=0; rd_idx=3 returns rd_data=0 with rd_valid one cycle after rd_en.
- In RUN, raise evt_in[4] before evt_in[2] -> lat_err=1 and lat_valid stays 0 after START arrives.
- Raise evt_in[2] and evt_in[4] in the same cycle -> equal timestamps, lat_cycles=0, lat_valid=1; rd_idx=12 returns rd_data=0.
- Use CNT_W=8 and run 300 cycles -> counter holds 255 and cnt_ovf=1; then clear coincident with a rise -> all outputs 0 and no capture.
- With ILKN_LAT_MINMAX_EN, run latencies 1000 then 400 with a clear between runs -> lat_min=400, lat_max=1000, run_cnt=2 after the second run.
